// File: rtl/spi_adc_multi.sv
// rtl/spi_adc_multi.sv - multi-lane SPI ADC frame reader
//
// Drives one shared CS/SCLK pair and samples NUM_CH MISO lanes in parallel.
// Each frame: SETUP (CS low, SCLK idle) -> SHIFT (FRAME_BITS SCLK periods)
// -> HOLD -> GAP (CS high) -> IDLE, or straight back to SETUP if trigger
// is still high on the last GAP cycle.
//
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   trigger          start request, level-sampled in IDLE / last GAP cycle
//   busy             high whenever the FSM is not IDLE
//   overrun          1-cycle pulse when trigger rises while busy (request dropped)
//   data             lane k at [k*DATA_BITS +: DATA_BITS]
//   data_valid       1-cycle pulse in the first GAP cycle, data updated with it
//   spi_miso         ADC DOUT lanes, sampled on the SCLK rising edge
//   spi_sclk         SPI clock, idles low
//   spi_cs_n         chip select, active low
//   sample_ts        (SPI_ADC_MULTI_TIMESTAMP_EN only) free-running clk count
//                    captured when CS falls, presented with data
//
// Optional feature macro: SPI_ADC_MULTI_TIMESTAMP_EN
module spi_adc_multi #(
  parameter int CLK_DIV     = 21,
  parameter int CS_SETUP    = 10,
  parameter int CS_HOLD     = 1,
  parameter int CS_IDLE_MIN = 5,
  parameter int FRAME_BITS  = 24,
  parameter int DATA_BITS   = 16,
  parameter int NUM_CH      = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        trigger,
  output logic                        busy,
  output logic                        overrun,
  output logic [NUM_CH*DATA_BITS-1:0] data,
  output logic                        data_valid,
  input  logic [NUM_CH-1:0]           spi_miso,
  output logic                        spi_sclk,
  output logic                        spi_cs_n
`ifdef SPI_ADC_MULTI_TIMESTAMP_EN
  ,
  output logic [31:0]                 sample_ts
`endif
);

  // SCLK low for the first ceil(CLK_DIV/2) cycles of each bit period.
  localparam int LOW_CYC = (CLK_DIV + 1) / 2;
  localparam int PH_MAX  = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_IDLE_MIN) ? CS_SETUP : CS_IDLE_MIN) :
                           ((CS_HOLD > CS_IDLE_MIN) ? CS_HOLD : CS_IDLE_MIN);
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]                ph_cnt;
  logic [DW-1:0]                div_cnt;
  logic [BW-1:0]                bit_cnt;
  logic [NUM_CH*DATA_BITS-1:0]  shreg, shreg_nx;
  logic                         trig_q;
  logic                         period_end;
  logic                         sclk_rise;
  logic                         start;
  logic                         frame_end;

  assign period_end = (state == S_SHIFT) && (div_cnt == DW'(CLK_DIV - 1));
  // The registered SCLK view goes high on the edge that takes div_cnt to LOW_CYC.
  assign sclk_rise  = (state == S_SHIFT) && (div_cnt == DW'(LOW_CYC - 1));
  assign start      = (state_nx == S_SETUP) && (state != S_SETUP);
  assign frame_end  = (state == S_HOLD) && (state_nx == S_GAP);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trigger) state_nx = S_SETUP;
      S_SETUP: if (ph_cnt == PW'(CS_SETUP - 1)) state_nx = S_SHIFT;
      S_SHIFT: if (period_end && (bit_cnt == BW'(FRAME_BITS - 1))) state_nx = S_HOLD;
      S_HOLD:  if (ph_cnt == PW'(CS_HOLD - 1)) state_nx = S_GAP;
      S_GAP:   if (ph_cnt == PW'(CS_IDLE_MIN - 1)) state_nx = trigger ? S_SETUP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Only the last DATA_BITS bits of the frame reach the lane registers, so
  // each frame fully replaces the previous contents without a clear.
  always_comb begin
    shreg_nx = shreg;
    for (int k = 0; k < NUM_CH; k++) begin
      shreg_nx[k*DATA_BITS +: DATA_BITS] =
        (shreg[k*DATA_BITS +: DATA_BITS] << 1) | DATA_BITS'(spi_miso[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ph_cnt     <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      trig_q <= trigger;

      if (state_nx != state)
        ph_cnt <= '0;
      else if (state == S_SETUP || state == S_HOLD || state == S_GAP)
        ph_cnt <= ph_cnt + 1'b1;

      if (state == S_SHIFT)
        div_cnt <= period_end ? '0 : div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (state != S_SHIFT)
        bit_cnt <= '0;
      else if (period_end)
        bit_cnt <= (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;

      if (sclk_rise && (bit_cnt >= BW'(FRAME_BITS - DATA_BITS)))
        shreg <= shreg_nx;

      data_valid <= frame_end;
      if (frame_end)
        data <= shreg;

      // A rise that is accepted as a new frame start is not an overrun.
      overrun <= trigger && !trig_q && (state != S_IDLE) && !start;
    end
  end

  assign busy     = (state != S_IDLE);
  assign spi_cs_n = !(state == S_SETUP || state == S_SHIFT || state == S_HOLD);
  assign spi_sclk = (state == S_SHIFT) && (div_cnt >= DW'(LOW_CYC));

`ifdef SPI_ADC_MULTI_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_lat;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_cnt    <= '0;
      ts_lat    <= '0;
      sample_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (start)
        ts_lat <= ts_cnt;
      if (frame_end)
        sample_ts <= ts_lat;
    end
  end
`endif

endmodule
